// File: rtl/tcp_client_if.sv
// Segment header bus between tcp_client and the TX/RX header datapath.
// master: the connection controller (consumes rx headers, produces tx headers).
// slave : the datapath side (produces rx headers, accepts tx headers).
interface tcp_client_if;
  logic        rx_valid_i;
  logic        rx_syn_i;
  logic        rx_ack_i;
  logic        rx_fin_i;
  logic        rx_rst_i;
  logic [31:0] rx_seq_i;
  logic [31:0] rx_ack_num_i;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        tx_syn_o;
  logic        tx_ack_o;
  logic        tx_fin_o;
  logic [31:0] tx_seq_o;
  logic [31:0] tx_ack_num_o;

  modport master (
    input  rx_valid_i, rx_syn_i, rx_ack_i, rx_fin_i, rx_rst_i,
    input  rx_seq_i, rx_ack_num_i, tx_ready_i,
    output tx_valid_o, tx_syn_o, tx_ack_o, tx_fin_o, tx_seq_o, tx_ack_num_o
  );

  modport slave (
    output rx_valid_i, rx_syn_i, rx_ack_i, rx_fin_i, rx_rst_i,
    output rx_seq_i, rx_ack_num_i, tx_ready_i,
    input  tx_valid_o, tx_syn_o, tx_ack_o, tx_fin_o, tx_seq_o, tx_ack_num_o
  );
endinterface

// File: rtl/tcp_client.sv
// Active-open TCP connection controller (client side of the handshake).
// Sends SYN, completes the three-way handshake, performs an active FIN
// close through TIME_WAIT, and aborts to CLOSED on a received RST.
// Optional feature: define TCP_CLIENT_RETRANSMIT_EN to enable SYN
// retransmission on RTO_CYCLES timeout with abort after MAX_RETRIES.
module tcp_client #(
  parameter int RTO_CYCLES  = 1000,
  parameter int MAX_RETRIES = 3,
  parameter int TW_CYCLES   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         active_open_i,
  input  logic         close_i,
  input  logic [31:0]  isn_i,
  tcp_client_if.master seg,
  output logic [3:0]   state_o,
  output logic         connected_o,
  output logic         abort_o
);

  typedef enum logic [3:0] {
    CLOSED      = 4'd0,
    SYN_SENT    = 4'd1,
    SEND_ACK    = 4'd2,
    ESTABLISHED = 4'd3,
    FIN_WAIT_1  = 4'd4,
    FIN_WAIT_2  = 4'd5,
    TIME_WAIT   = 4'd6
  } state_e;

  localparam int              TW_W    = $clog2(TW_CYCLES + 1);
  localparam logic [TW_W-1:0] TW_LAST = TW_W'(TW_CYCLES);

  state_e            state_q, state_d;
  logic [31:0]       snd_nxt_q, snd_nxt_d;
  logic [31:0]       rcv_nxt_q, rcv_nxt_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_syn_q, tx_syn_d;
  logic              tx_ack_q, tx_ack_d;
  logic              tx_fin_q, tx_fin_d;
  logic [31:0]       tx_seq_q, tx_seq_d;
  logic [31:0]       tx_ack_num_q, tx_ack_num_d;
  logic              connected_q;
  logic              abort_q, abort_d;
  logic [TW_W-1:0]   tw_q, tw_d;

  logic              tx_fire;
  logic              tx_idle;
  logic              ack_match;
  logic              rst_hit;
  logic [31:0]       rx_seq_inc;

  assign tx_fire    = tx_valid_q && seg.tx_ready_i;
  assign tx_idle    = !tx_valid_q;
  assign ack_match  = seg.rx_ack_num_i == snd_nxt_q;
  assign rst_hit    = seg.rx_valid_i && seg.rx_rst_i && (state_q != CLOSED);
  assign rx_seq_inc = seg.rx_seq_i + 32'd1;

`ifdef TCP_CLIENT_RETRANSMIT_EN
  localparam int               RTO_W     = $clog2(RTO_CYCLES + 1);
  localparam logic [RTO_W-1:0] RTO_LAST  = RTO_W'(RTO_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic [31:0]      isn_q, isn_d;
  logic [RTO_W-1:0] rto_q, rto_d;
  logic [3:0]       retry_q, retry_d;
  logic             timeout;

  // The timer is loaded with 1 on the SYN accept edge, so reaching RTO_LAST
  // means RTO_CYCLES cycles have elapsed since the SYN went out.
  assign timeout = (state_q == SYN_SENT) && tx_idle && (rto_q == RTO_LAST);
`endif

  // Next-state, header queueing and sequence-number bookkeeping.
  always_comb begin
    state_d      = state_q;
    snd_nxt_d    = snd_nxt_q;
    rcv_nxt_d    = rcv_nxt_q;
    tx_valid_d   = tx_valid_q && !tx_fire;
    tx_syn_d     = tx_syn_q;
    tx_ack_d     = tx_ack_q;
    tx_fin_d     = tx_fin_q;
    tx_seq_d     = tx_seq_q;
    tx_ack_num_d = tx_ack_num_q;
    abort_d      = 1'b0;
    tw_d         = tw_q;
`ifdef TCP_CLIENT_RETRANSMIT_EN
    isn_d        = isn_q;
    retry_d      = retry_q;
    rto_d        = rto_q;
    if (state_q == SYN_SENT) begin
      if (tx_fire) begin
        rto_d = RTO_W'(1);
      end else if (tx_idle && !timeout) begin
        rto_d = rto_q + RTO_W'(1);
      end
    end
`endif

    case (state_q)
      CLOSED: begin
        if (active_open_i) begin
          snd_nxt_d    = isn_i + 32'd1;
          tx_valid_d   = 1'b1;
          tx_syn_d     = 1'b1;
          tx_ack_d     = 1'b0;
          tx_fin_d     = 1'b0;
          tx_seq_d     = isn_i;
          tx_ack_num_d = 32'd0;
          state_d      = SYN_SENT;
`ifdef TCP_CLIENT_RETRANSMIT_EN
          isn_d        = isn_i;
          retry_d      = '0;
          rto_d        = '0;
`endif
        end
      end

      SYN_SENT: begin
        if (tx_idle && seg.rx_valid_i && seg.rx_syn_i && seg.rx_ack_i &&
            !seg.rx_rst_i && ack_match) begin
          rcv_nxt_d    = rx_seq_inc;
          tx_valid_d   = 1'b1;
          tx_syn_d     = 1'b0;
          tx_ack_d     = 1'b1;
          tx_fin_d     = 1'b0;
          tx_seq_d     = snd_nxt_q;
          tx_ack_num_d = rx_seq_inc;
          state_d      = SEND_ACK;
        end
`ifdef TCP_CLIENT_RETRANSMIT_EN
        else if (timeout) begin
          if (retry_q == RETRY_MAX) begin
            abort_d = 1'b1;
            state_d = CLOSED;
          end else begin
            retry_d      = retry_q + 4'd1;
            tx_valid_d   = 1'b1;
            tx_syn_d     = 1'b1;
            tx_ack_d     = 1'b0;
            tx_fin_d     = 1'b0;
            tx_seq_d     = isn_q;
            tx_ack_num_d = 32'd0;
          end
        end
`endif
      end

      SEND_ACK: begin
        if (tx_fire) begin
          state_d = ESTABLISHED;
        end
      end

      ESTABLISHED: begin
        if (close_i) begin
          tx_valid_d   = 1'b1;
          tx_syn_d     = 1'b0;
          tx_ack_d     = 1'b1;
          tx_fin_d     = 1'b1;
          tx_seq_d     = snd_nxt_q;
          tx_ack_num_d = rcv_nxt_q;
          snd_nxt_d    = snd_nxt_q + 32'd1;
          state_d      = FIN_WAIT_1;
        end
      end

      FIN_WAIT_1: begin
        if (tx_idle && seg.rx_valid_i && seg.rx_ack_i && ack_match) begin
          if (seg.rx_fin_i) begin
            rcv_nxt_d    = rx_seq_inc;
            tx_valid_d   = 1'b1;
            tx_syn_d     = 1'b0;
            tx_ack_d     = 1'b1;
            tx_fin_d     = 1'b0;
            tx_seq_d     = snd_nxt_q;
            tx_ack_num_d = rx_seq_inc;
            state_d      = TIME_WAIT;
          end else begin
            state_d = FIN_WAIT_2;
          end
        end
      end

      FIN_WAIT_2: begin
        if (seg.rx_valid_i && seg.rx_fin_i) begin
          rcv_nxt_d    = rx_seq_inc;
          tx_valid_d   = 1'b1;
          tx_syn_d     = 1'b0;
          tx_ack_d     = 1'b1;
          tx_fin_d     = 1'b0;
          tx_seq_d     = snd_nxt_q;
          tx_ack_num_d = rx_seq_inc;
          state_d      = TIME_WAIT;
        end
      end

      TIME_WAIT: begin
        // Hold time is counted only after the final ACK has left.
        if (tx_fire) begin
          tw_d = TW_W'(1);
        end else if (tx_idle) begin
          if (tw_q == TW_LAST) begin
            state_d = CLOSED;
          end else begin
            tw_d = tw_q + TW_W'(1);
          end
        end
      end

      default: state_d = CLOSED;
    endcase

    // A received RST overrides everything decided above in the same cycle.
    if (rst_hit) begin
      state_d    = CLOSED;
      snd_nxt_d  = snd_nxt_q;
      rcv_nxt_d  = rcv_nxt_q;
      tx_valid_d = 1'b0;
      abort_d    = 1'b1;
    end
  end

  // State, header and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLOSED;
      snd_nxt_q    <= '0;
      rcv_nxt_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_syn_q     <= 1'b0;
      tx_ack_q     <= 1'b0;
      tx_fin_q     <= 1'b0;
      tx_seq_q     <= '0;
      tx_ack_num_q <= '0;
      connected_q  <= 1'b0;
      abort_q      <= 1'b0;
      tw_q         <= '0;
`ifdef TCP_CLIENT_RETRANSMIT_EN
      isn_q        <= '0;
      rto_q        <= '0;
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      snd_nxt_q    <= snd_nxt_d;
      rcv_nxt_q    <= rcv_nxt_d;
      tx_valid_q   <= tx_valid_d;
      tx_syn_q     <= tx_syn_d;
      tx_ack_q     <= tx_ack_d;
      tx_fin_q     <= tx_fin_d;
      tx_seq_q     <= tx_seq_d;
      tx_ack_num_q <= tx_ack_num_d;
      connected_q  <= (state_d == ESTABLISHED);
      abort_q      <= abort_d;
      tw_q         <= tw_d;
`ifdef TCP_CLIENT_RETRANSMIT_EN
      isn_q        <= isn_d;
      rto_q        <= rto_d;
      retry_q      <= retry_d;
`endif
    end
  end

  assign seg.tx_valid_o   = tx_valid_q;
  assign seg.tx_syn_o     = tx_syn_q;
  assign seg.tx_ack_o     = tx_ack_q;
  assign seg.tx_fin_o     = tx_fin_q;
  assign seg.tx_seq_o     = tx_seq_q;
  assign seg.tx_ack_num_o = tx_ack_num_q;
  assign state_o          = state_q;
  assign connected_o      = connected_q;
  assign abort_o          = abort_q;

endmodule

// File: doc/tcp_client.md
# tcp_client

Active-open TCP connection controller: the client end of the handshake whose passive (server) side is handled by the existing LISTEN/SYN_RCVD/ESTABLISHED server FSM. On a request it emits SYN, waits for SYN+ACK, completes the three-way handshake, tracks sequence/acknowledge numbers, and performs an active close (FIN/ACK) or aborts on RST. It sits between host control logic and the segment TX/RX datapath; only header flags and numbers are handled, not payload.

## Interface
- RTO_CYCLES, 1000: retransmission timeout in clk cycles (≥2).
- MAX_RETRIES, 3: SYN retransmissions before abort (1–15).
- TW_CYCLES, 64: TIME_WAIT hold in clk cycles (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- active_open_i  in  1  one-cycle connect request; honoured only in CLOSED.
- close_i  in  1  one-cycle close request; honoured only in ESTABLISHED.
- isn_i  in  32  initial sequence number, sampled when active_open_i is accepted.
- rx_valid_i  in  1  received header valid (no backpressure; one header per cycle).
- rx_syn_i, rx_ack_i, rx_fin_i, rx_rst_i  in  1 each  received flags.
- rx_seq_i  in  32  received sequence number.
- rx_ack_num_i  in  32  received acknowledge number.
- tx_valid_o  out  1  header to send.
- tx_ready_i  in  1  transmitter accepts header when tx_valid_o && tx_ready_i.
- tx_syn_o, tx_ack_o, tx_fin_o  out  1 each  transmitted flags.
- tx_seq_o, tx_ack_num_o  out  32  transmitted sequence / acknowledge numbers.
- state_o  out  4  current state encoding.
- connected_o  out  1  high in ESTABLISHED.
- abort_o  out  1  one-cycle pulse on RST-abort or retry exhaustion.

## Operation
- States/encoding: CLOSED=0, SYN_SENT=1, SEND_ACK=2, ESTABLISHED=3, FIN_WAIT_1=4, FIN_WAIT_2=5, TIME_WAIT=6.
- Registers: snd_nxt, rcv_nxt (32 b, all adds modulo 2^32, wrap silently).
- CLOSED + active_open_i: snd_nxt←isn_i+1, queue SYN with seq=isn_i, ack flag 0 → SYN_SENT.
- SYN_SENT: header with rx_syn&&rx_ack&&!rx_rst and rx_ack_num==snd_nxt: rcv_nxt←rx_seq+1, queue ACK (seq=snd_nxt, ack=rcv_nxt) → SEND_ACK. Mismatched ack number or missing flag: ignored.
- SEND_ACK: on ACK handshake completion → ESTABLISHED.
- ESTABLISHED + close_i: queue FIN+ACK (seq=snd_nxt), snd_nxt←snd_nxt+1 → FIN_WAIT_1.
- FIN_WAIT_1: rx_ack with rx_ack_num==snd_nxt → FIN_WAIT_2; if rx_fin also set, rcv_nxt←rx_seq+1, queue ACK → TIME_WAIT.
- FIN_WAIT_2: rx_fin → rcv_nxt←rx_seq+1, queue ACK → TIME_WAIT.
- TIME_WAIT: after ACK accepted, count TW_CYCLES, then → CLOSED.
- rx_rst_i with rx_valid_i in any state except CLOSED: drop queued header, abort_o pulse → CLOSED (RST wins over every simultaneous event including close_i).
- Headers received in CLOSED are ignored; client never emits RST.

## Timing
- Reset: state CLOSED, all tx_* outputs 0, snd_nxt/rcv_nxt 0, connected_o 0, abort_o 0, timers/retry count 0.
- All outputs registered; queued header appears on tx_* the cycle after the triggering input and is held stable until accepted.
- State advances past a send only on the accept cycle; request inputs outside their legal state are dropped.
- connected_o asserts the cycle after the ACK handshake in SEND_ACK.

## Configuration
- TCP_CLIENT_RETRANSMIT_EN defined: in SYN_SENT a counter starts at SYN acceptance; at RTO_CYCLES without valid SYN+ACK, SYN (same seq=isn) is re-queued and retry count increments; SYN+ACK arriving on timeout cycle wins. After MAX_RETRIES retransmissions, next timeout → abort_o pulse, CLOSED.
- Undefined: no timer or retry logic; SYN_SENT waits indefinitely (exit only via valid SYN+ACK, RST or reset).

## Test plan
- isn=0x0000_1000, tx_ready=1, reply SYN+ACK seq=0x5000 ack=0x1001 -> SYN seq=0x1000, then ACK seq=0x1001 ack=0x5001, state_o=3, connected_o=1.
- isn=0xFFFF_FFFF, reply ack=0x0000_0000 -> accepted, snd_nxt wraps to 0, ACK seq=0x0.
- SYN+ACK with ack=0x1002 -> ignored, stays SYN_SENT; correct ack later -> ESTABLISHED.
- ESTABLISHED, close_i, reply ACK ack=snd_nxt then FIN seq=0x6000 -> FIN_WAIT_1, FIN_WAIT_2, ACK ack=0x6001, TIME_WAIT, CLOSED after TW_CYCLES.
- RST during SYN_SENT with tx_ready=0 and SYN pending -> tx_valid drops, abort_o one cycle, state_o=0.
- With TCP_CLIENT_RETRANSMIT_EN, RTO_CYCLES=10, MAX_RETRIES=2, no reply -> 3 SYNs total 10 cycles apart, then abort_o and CLOSED.
